// File: rtl/fetch_unit_pkg.sv
// cpu_pkg: opcodes, fetch_unit state encoding and default program.
// Shared by fetch_unit, program_rom and the bench.
package cpu_pkg;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_LOADX  = 3'd1;
  localparam logic [2:0] OP_ADD    = 3'd2;
  localparam logic [2:0] OP_SUB    = 3'd3;
  localparam logic [2:0] OP_SHR    = 3'd4;
  localparam logic [2:0] OP_STOREZ = 3'd5;
  localparam logic [2:0] OP_CLR    = 3'd6;
  localparam logic [2:0] OP_HALT   = 3'd7;

  localparam logic [1:0] FU_IDLE    = 2'd0;
  localparam logic [1:0] FU_FETCH   = 2'd1;
  localparam logic [1:0] FU_PRESENT = 2'd2;
  localparam logic [1:0] FU_HALTED  = 2'd3;

  // Entry 0 is the rightmost; program computes Z = (6+4)/2.
  localparam logic [15:0][6:0] DEFAULT_PROG = {
    {9{OP_NOP, 4'd0}},
    {OP_STOREZ, 4'd0},
    {OP_SHR, 4'd0},
    {OP_ADD, 4'd0},
    {OP_LOADX, 4'd4},
    {OP_ADD, 4'd0},
    {OP_LOADX, 4'd6},
    {OP_CLR, 4'd0}
  };

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction valid/ready handshake bundle.
// master = fetch_unit, slave = control unit.
interface fetch_unit_if #(
  parameter int OP_W   = 3,
  parameter int DATA_W = 4
);
  logic              instr_valid;
  logic              instr_ready;
  logic [OP_W-1:0]   opcode;
  logic [DATA_W-1:0] operand;

  modport master (
    output instr_valid, opcode, operand,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, opcode, operand,
    output instr_ready
  );
endinterface

// File: rtl/fetch_unit_rom.sv
// program_rom: combinational {opcode, operand} lookup by pc.
// Addresses at or beyond PROG_LEN read NOP/0.
module program_rom
  import cpu_pkg::*;
#(
  parameter int PROG_LEN = 7,
  parameter int PC_W     = 4,
  parameter int OP_W     = 3,
  parameter int DATA_W   = 4,
  parameter logic [2**PC_W-1:0][OP_W+DATA_W-1:0] PROG = DEFAULT_PROG
) (
  input  logic [PC_W-1:0]   addr_i,
  output logic [OP_W-1:0]   op_o,
  output logic [DATA_W-1:0] imm_o
);

  // ROM read, masked past the program end
  always_comb begin
    {op_o, imm_o} = '0;
    if (int'(addr_i) < PROG_LEN) begin
      {op_o, imm_o} = PROG[addr_i];
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: pc + program ROM, one instruction per valid/ready.
// Optional HALTED state enabled by `define FETCH_UNIT_HALT_EN.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int PROG_LEN = 7,
  parameter int PC_W     = 4,
  parameter int OP_W     = 3,
  parameter int DATA_W   = 4,
  parameter logic [2**PC_W-1:0][OP_W+DATA_W-1:0] PROG = DEFAULT_PROG
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  fetch_unit_if.master    bus,
  output logic [PC_W-1:0] pc,
  output logic            wrap,
  output logic            busy,
  output logic            halted
);

  logic [1:0]        state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [OP_W-1:0]   op_q, op_d, rom_op;
  logic [DATA_W-1:0] imm_q, imm_d, rom_imm;
  logic              wrap_q, wrap_d;
  logic              last;

  program_rom #(
    .PROG_LEN(PROG_LEN),
    .PC_W(PC_W),
    .OP_W(OP_W),
    .DATA_W(DATA_W),
    .PROG(PROG)
  ) u_rom (
    .addr_i(pc_q),
    .op_o(rom_op),
    .imm_o(rom_imm)
  );

  assign last = pc_q == PC_W'(PROG_LEN - 1);

  // Next state: fetch latches ROM, present waits for accept
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    op_d    = op_q;
    imm_d   = imm_q;
    wrap_d  = 1'b0;
    unique case (state_q)
      FU_IDLE: begin
        if (start) state_d = FU_FETCH;
      end
      FU_FETCH: begin
        op_d    = rom_op;
        imm_d   = rom_imm;
        state_d = FU_PRESENT;
      end
      FU_PRESENT: begin
        if (bus.instr_ready) begin
          pc_d    = last ? '0 : pc_q + PC_W'(1);
          wrap_d  = last;
          state_d = FU_FETCH;
`ifdef FETCH_UNIT_HALT_EN
          if (op_q == OP_W'(OP_HALT)) state_d = FU_HALTED;
`endif
        end
      end
`ifdef FETCH_UNIT_HALT_EN
      FU_HALTED: begin
        if (start) state_d = FU_FETCH;
      end
`endif
      default: state_d = FU_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FU_IDLE;
      pc_q    <= '0;
      op_q    <= '0;
      imm_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      op_q    <= op_d;
      imm_q   <= imm_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.instr_valid = state_q == FU_PRESENT;
  assign bus.opcode      = op_q;
  assign bus.operand     = imm_q;
  assign pc              = pc_q;
  assign wrap            = wrap_q;
  assign busy            = (state_q == FU_FETCH)
                         | (state_q == FU_PRESENT);
`ifdef FETCH_UNIT_HALT_EN
  assign halted = state_q == FU_HALTED;
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table vectors, corner sequences, random vs model.
// Honours `FETCH_UNIT_HALT_EN for the HALT-program instance.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam logic [15:0][6:0] HPROG = {
    DEFAULT_PROG[15:3], {OP_HALT, 4'd0}, DEFAULT_PROG[1:0]
  };

  typedef struct {
    logic       rdy;
    logic       vld;
    logic [2:0] op;
    logic [3:0] imm;
    logic [3:0] pc;
    logic       wrap;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start0, start1, start2;
  logic [3:0] pc0, pc1, pc2;
  logic wrap0, wrap1, wrap2;
  logic busy0, busy1, busy2;
  logic halt0, halt1, halt2;
  int ntests = 0;
  int nfail = 0;

  fetch_unit_if #(.OP_W(3), .DATA_W(4)) b0 ();
  fetch_unit_if #(.OP_W(3), .DATA_W(4)) b1 ();
  fetch_unit_if #(.OP_W(3), .DATA_W(4)) b2 ();

  fetch_unit #(.PROG_LEN(7)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .bus(b0.master), .pc(pc0), .wrap(wrap0),
    .busy(busy0), .halted(halt0)
  );

  fetch_unit #(.PROG_LEN(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .bus(b1.master), .pc(pc1), .wrap(wrap1),
    .busy(busy1), .halted(halt1)
  );

  fetch_unit #(.PROG_LEN(7), .PROG(HPROG)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .bus(b2.master), .pc(pc2), .wrap(wrap2),
    .busy(busy2), .halted(halt2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk0(string nm, logic v, logic [3:0] p,
                      logic [2:0] o, logic [3:0] i);
    chk({nm, " valid"}, b0.instr_valid, v);
    chk({nm, " pc"}, pc0, p);
    if (v) begin
      chk({nm, " op"}, b0.opcode, o);
      chk({nm, " imm"}, b0.operand, i);
    end
  endtask

  vec_t tbl[16];
  int   mop[7] = '{6, 1, 2, 1, 2, 4, 5};
  int   mimm[7] = '{0, 6, 0, 4, 0, 0, 0};
  int   mpc;
  bit   mph, mw, r;

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, OP_CLR, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 1, 0};
    tbl[3]  = '{1, 1, OP_LOADX, 6, 1, 0};
    tbl[4]  = '{1, 0, 0, 0, 2, 0};
    tbl[5]  = '{1, 1, OP_ADD, 0, 2, 0};
    tbl[6]  = '{1, 0, 0, 0, 3, 0};
    tbl[7]  = '{1, 1, OP_LOADX, 4, 3, 0};
    tbl[8]  = '{1, 0, 0, 0, 4, 0};
    tbl[9]  = '{1, 1, OP_ADD, 0, 4, 0};
    tbl[10] = '{1, 0, 0, 0, 5, 0};
    tbl[11] = '{1, 1, OP_SHR, 0, 5, 0};
    tbl[12] = '{1, 0, 0, 0, 6, 0};
    tbl[13] = '{1, 1, OP_STOREZ, 0, 6, 0};
    tbl[14] = '{1, 0, 0, 0, 0, 1};
    tbl[15] = '{1, 1, OP_CLR, 0, 0, 0};

    rst_n = 1'b0;
    {start0, start1, start2} = '0;
    b0.instr_ready = 1'b0;
    b1.instr_ready = 1'b0;
    b2.instr_ready = 1'b0;
    #12;
    chk0("reset", 1'b0, 4'd0, 3'd0, 4'd0);
    chk("reset op", b0.opcode, 0);
    chk("reset imm", b0.operand, 0);
    chk("reset wrap", wrap0, 0);
    chk("reset busy", busy0, 0);
    chk("reset halted", halt0, 0);
    chk("reset halted2", halt2, 0);
    @(negedge clk) rst_n = 1'b1;

    b0.instr_ready = 1'b1;
    step();
    chk("idle valid", b0.instr_valid, 0);
    chk("idle busy", busy0, 0);

    {start0, start1, start2} = '1;
    b1.instr_ready = 1'b1;
    b2.instr_ready = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      b0.instr_ready = tbl[n-1].rdy;
      step();
      if (n == 1) {start0, start1, start2} = '0;
      chk0("stream", tbl[n-1].vld, tbl[n-1].pc,
           tbl[n-1].op, tbl[n-1].imm);
      chk("stream wrap", wrap0, tbl[n-1].wrap);
      chk("stream busy", busy0, 1);
      chk("len1 valid", b1.instr_valid, (n % 2) == 0);
      chk("len1 pc", pc1, 0);
      chk("len1 wrap", wrap1, (n % 2 == 1) && n >= 3);
      if (n % 2 == 0) begin
        chk("len1 op", b1.opcode, OP_CLR);
        chk("len1 imm", b1.operand, 0);
      end
      if (n == 6) begin
        chk("halt pres op", b2.opcode, OP_HALT);
        chk("halt pres pc", pc2, 2);
        chk("halt pres valid", b2.instr_valid, 1);
      end
      if (n == 7 || n == 8) begin
        chk("halt pc", pc2, 3);
`ifdef FETCH_UNIT_HALT_EN
        chk("halt halted", halt2, 1);
        chk("halt valid", b2.instr_valid, 0);
        chk("halt busy", busy2, 0);
`else
        chk("nohalt halted", halt2, 0);
        chk("nohalt valid", b2.instr_valid, n == 8);
`endif
      end
    end

    start2 = 1'b1;
    step();
    start2 = 1'b0;
    chk0("adv1", 1'b0, 4'd1, 3'd0, 4'd0);
`ifdef FETCH_UNIT_HALT_EN
    chk("resume halted", halt2, 0);
    chk("resume busy", busy2, 1);
    chk("resume pc", pc2, 3);
`endif
    step();
    chk0("adv2", 1'b1, 4'd1, OP_LOADX, 4'd6);
`ifdef FETCH_UNIT_HALT_EN
    chk("resume valid", b2.instr_valid, 1);
    chk("resume op", b2.opcode, OP_LOADX);
    chk("resume imm", b2.operand, 4);
    chk("resume pc2", pc2, 3);
`else
    chk("ign start pc", pc2, 1);
    chk("ign start halted", halt2, 0);
`endif
    step();
    step();
    chk0("at pc2", 1'b1, 4'd2, OP_ADD, 4'd0);

    start0 = 1'b1;
    b0.instr_ready = 1'b0;
    step();
    chk0("busy start", 1'b1, 4'd2, OP_ADD, 4'd0);
    chk("busy start busy", busy0, 1);
    start0 = 1'b0;
    b0.instr_ready = 1'b1;
    step();
    chk0("add acc", 1'b0, 4'd3, 3'd0, 4'd0);
    step();
    b0.instr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk0("hold", 1'b1, 4'd3, OP_LOADX, 4'd4);
      step();
    end
    chk0("hold end", 1'b1, 4'd3, OP_LOADX, 4'd4);
    b0.instr_ready = 1'b1;
    step();
    chk0("hold acc", 1'b0, 4'd4, 3'd0, 4'd0);
    step();
    step();
    step();
    chk0("at pc5", 1'b1, 4'd5, OP_SHR, 4'd0);

    #3 rst_n = 1'b0;
    #1;
    chk("arst valid", b0.instr_valid, 0);
    chk("arst pc", pc0, 0);
    chk("arst op", b0.opcode, 0);
    chk("arst busy", busy0, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post rst idle", busy0, 0);
      chk("post rst valid", b0.instr_valid, 0);
    end
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk("restart busy", busy0, 1);
    step();
    chk0("restart", 1'b1, 4'd0, OP_CLR, 4'd0);

    mpc = 0;
    mph = 1'b1;
    mw = 1'b0;
    for (int k = 0; k < 400; k++) begin
      r = bit'($urandom_range(0, 1));
      b0.instr_ready = r;
      start0 = ($urandom_range(0, 7) == 0);
      step();
      if (mph && r) begin
        mw = (mpc == 6);
        mpc = (mpc + 1) % 7;
        mph = 1'b0;
      end else begin
        mw = 1'b0;
        if (!mph) mph = 1'b1;
      end
      chk0("rand", mph, 4'(mpc), 3'(mop[mpc]), 4'(mimm[mpc]));
      chk("rand wrap", wrap0, mw);
      chk("rand busy", busy0, 1);
    end
    start0 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
